// File: rtl/fcvt_sched_if.sv
// fcvt_sched bus: requester handshake, response strobe and
// conversion-unit side, grouped for the scheduler port.
interface fcvt_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_data;
  logic               rsp_ovf;
  logic               cvt_valid;
  logic               cvt_op;
  logic [31:0]        cvt_x;
  logic [31:0]        cvt_y;
  logic               busy;

  modport master (
    output req_valid, req_op, req_data, cvt_y,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf,
    input  cvt_valid, cvt_op, cvt_x, busy
  );

  modport slave (
    input  req_valid, req_op, req_data, cvt_y,
    output req_ready, rsp_valid, rsp_data, rsp_ovf,
    output cvt_valid, cvt_op, cvt_x, busy
  );
endinterface

// File: rtl/fcvt_sched.sv
// Round-robin scheduler sharing one fixed-latency ftoi/itof unit.
// Optional ftoi saturation is enabled by defining FCVT_SAT_EN.
module fcvt_sched #(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  fcvt_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef struct packed {
    logic          v;
    logic          op;
    logic [IW-1:0] own;
`ifdef FCVT_SAT_EN
    logic          sgn;
    logic [7:0]    ex;
    logic          nan;
`endif
  } tag_t;

  logic [NREQ-1:0] out_q, out_d;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx;
  logic            gany, gok;
  logic            gop;
  logic [31:0]     gx;
  logic            cvt_valid_q, cvt_op_q;
  logic [31:0]     cvt_x_q;
  tag_t            tag_in;
  tag_t            pipe_q [LAT+1];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
`ifdef FCVT_SAT_EN
  logic            ovf_q, ovf_d;
`endif

  // First eligible requester scanning upward from the pointer
  always_comb begin
    int            idx;
    logic [IW-1:0] si;
    idx  = 0;
    si   = '0;
    gany = 1'b0;
    gidx = '0;
    gop  = 1'b0;
    gx   = '0;
    gnt  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      si = IW'(idx);
      if (!gany && bus.req_valid[si] && !out_q[si]) begin
        gany = 1'b1;
        gidx = si;
        gop  = bus.req_op[si];
        gx   = bus.req_data[idx*32 +: 32];
      end
    end
    gok = gany & rstn;
    if (gok) gnt[gidx] = 1'b1;
  end

  // Tag entering the pipe, response decode and bookkeeping
  always_comb begin
    tag_in     = '0;
    tag_in.v   = gok;
    tag_in.op  = gop;
    tag_in.own = gidx;
`ifdef FCVT_SAT_EN
    tag_in.sgn = gx[31];
    tag_in.ex  = gx[30:23];
    tag_in.nan = (&gx[30:23]) & (|gx[22:0]);
`endif
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef FCVT_SAT_EN
    ovf_d = ovf_q;
`endif
    if (pipe_q[LAT].v) begin
      rsp_valid_d[pipe_q[LAT].own] = 1'b1;
      rsp_data_d = bus.cvt_y;
`ifdef FCVT_SAT_EN
      ovf_d = 1'b0;
      if (!pipe_q[LAT].op && pipe_q[LAT].ex >= 8'd158) begin
        ovf_d = 1'b1;
        rsp_data_d = (pipe_q[LAT].sgn && !pipe_q[LAT].nan) ?
                     32'h8000_0000 : 32'h7FFF_FFFF;
      end
`endif
    end
    out_d = (out_q & ~rsp_valid_d) | gnt;
    ptr_d = ptr_q;
    if (gok) ptr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
  end

  // Pointer, outstanding bits, issue and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      out_q       <= '0;
      cvt_valid_q <= 1'b0;
      cvt_op_q    <= 1'b0;
      cvt_x_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef FCVT_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      cvt_valid_q <= gok;
      if (gok) begin
        cvt_op_q <= gop;
        cvt_x_q  <= gx;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef FCVT_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Owner tags travel alongside the unit, aligned with cvt_y
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s <= LAT; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int s = 1; s <= LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef FCVT_SAT_EN
  assign bus.rsp_ovf   = ovf_q;
`else
  assign bus.rsp_ovf   = 1'b0;
`endif
  assign bus.cvt_valid = cvt_valid_q;
  assign bus.cvt_op    = cvt_op_q;
  assign bus.cvt_x     = cvt_x_q;
  assign bus.busy      = |out_q;
endmodule

// File: tb/tb_fcvt_sched.sv
// Scoreboard bench for fcvt_sched with a behavioural
// conversion unit returning cvt_x ^ A5A5A5A5 after LAT cycles.
module tb_fcvt_sched;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [2:0]  own;
    logic [31:0] data;
    logic        ovf;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb [$];
  logic [31:0] m [LAT];
  logic acc_prev = 1'b0;
  logic op_prev = 1'b0;
  logic [31:0] x_prev = '0;

  always #5 clk = ~clk;

  fcvt_sched_if #(.NREQ(NREQ)) bus();

  fcvt_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    m[0] <= bus.cvt_x ^ KEY;
    for (int s = 1; s < LAT; s++) m[s] <= m[s-1];
  end
  assign bus.cvt_y = m[LAT-1];

  task automatic check(string tag, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] model(logic op,
                                        logic [31:0] x);
    logic [32:0] r;
    r = {1'b0, x ^ KEY};
`ifdef FCVT_SAT_EN
    if (!op && x[30:23] >= 8'd158) begin
      if (x[31] && !((&x[30:23]) && (|x[22:0])))
        r = {1'b1, 32'h8000_0000};
      else
        r = {1'b1, 32'h7FFF_FFFF};
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] r;
    logic        acc;
    logic        aop;
    logic [31:0] ax;
    acc = 1'b0;
    aop = 1'b0;
    ax  = '0;
    if (!rstn) begin
      sb.delete();
      acc_prev <= 1'b0;
    end else begin
      check("cvt_valid", 64'(bus.cvt_valid), 64'(acc_prev));
      if (acc_prev) begin
        check("cvt_x", 64'(bus.cvt_x), 64'(x_prev));
        check("cvt_op", 64'(bus.cvt_op), 64'(op_prev));
      end
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexp", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 64'(bus.rsp_valid),
                64'(1 << e.own));
          check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          check("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end
      check("ready_1hot", 64'($countones(bus.req_ready) > 1),
            64'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc = 1'b1;
          aop = bus.req_op[i];
          ax  = bus.req_data[i*32 +: 32];
          r   = model(aop, ax);
          e.own  = 3'(i);
          e.data = r[31:0];
          e.ovf  = r[32];
          e.due  = 32'(cyc + LAT + 2);
          sb.push_back(e);
        end
      end
      acc_prev <= acc;
      op_prev  <= aop;
      x_prev   <= ax;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rspv", 64'(bus.rsp_valid), 64'd0);
    check("rst_cvtv", 64'(bus.cvt_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_data", 64'(bus.rsp_data), 64'd0);
    check("rst_ovf", 64'(bus.rsp_ovf), 64'd0);
    check("rst_cvtop", 64'(bus.cvt_op), 64'd0);
    check("rst_cvtx", 64'(bus.cvt_x), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic do_one(string tag, logic op, logic [31:0] x,
                        logic [31:0] ed, logic eo);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_op[0] = op;
    bus.req_data[31:0] = x;
    @(negedge clk);
    check({tag, "_acc"}, 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_issue"}, 64'(bus.cvt_valid), 64'd1);
        check({tag, "_x"}, 64'(bus.cvt_x), 64'(x));
      end
      if (bus.rsp_valid[0]) begin
        got = 1'b1;
        check({tag, "_lat"}, 64'(k), 64'(LAT + 2));
        check({tag, "_data"}, 64'(bus.rsp_data), 64'(ed));
        check({tag, "_ovf"}, 64'(bus.rsp_ovf), 64'(eo));
      end
    end
    if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic contention();
    logic [1:0] tbl [4];
    logic [1:0] acc;
    tbl = '{2'b01, 2'b10, 2'b00, 2'b00};
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.req_op = 2'b10;
    bus.req_data = {32'h2222_0000, 32'h1111_0000};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("cont_ready", 64'(bus.req_ready), 64'(tbl[c % 4]));
      check("cont_busy", 64'(bus.busy), 64'(c != 0));
      if (c == 4)
        check("cont_rsp0", 64'(bus.rsp_valid), 64'b01);
      if (c == 5) begin
        check("b2b_rsp1", 64'(bus.rsp_valid), 64'b10);
        check("b2b_acc1", 64'(bus.req_ready), 64'b10);
      end
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk); #1;
      if (acc[0]) bus.req_data[31:0] = $urandom;
      if (acc[1]) bus.req_data[63:32] = $urandom;
    end
    bus.req_valid = '0;
    repeat (8) @(posedge clk);
  endtask

  task automatic midflight();
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_op = '0;
    bus.req_data[31:0] = 32'h4040_0000;
    @(negedge clk);
    check("mid_acc", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_cvtv", 64'(bus.cvt_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("mid_norsp", 64'(bus.rsp_valid), 64'd0);
      check("mid_idle", 64'(bus.busy), 64'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("mid_ptr0", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_data = '0;
    apply_reset();
    contention();
    apply_reset();
    do_one("single", 1'b0, 32'h3FC0_0000, 32'h9A65_A5A5, 1'b0);
    midflight();
`ifdef FCVT_SAT_EN
    do_one("sat_pos", 1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
    do_one("sat_neg", 1'b0, 32'hCF00_0000, 32'h8000_0000, 1'b1);
    do_one("sat_nan", 1'b0, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1);
    do_one("sat_edge", 1'b0, 32'h4EFF_FFFF, 32'hEB5A_5A5A, 1'b0);
    do_one("sat_itof", 1'b1, 32'h4F00_0000, 32'hEAA5_A5A5, 1'b0);
`else
    do_one("nosat_big", 1'b0, 32'h4F00_0000, 32'hEAA5_A5A5, 1'b0);
    do_one("nosat_neg", 1'b0, 32'hCF00_0000, 32'h6AA5_A5A5, 1'b0);
`endif
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
